// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-reprogrammable video timing generator with request lead
module video_timing_gen #(
    parameter int W        = 12,
    parameter int PIPE_DLY = 4,
    parameter int FCNT_W   = 10
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_en,
    input  logic              I_cfg_valid,
    output logic              O_cfg_ready,
    input  logic [W-1:0]      I_h_total,
    input  logic [W-1:0]      I_h_sync,
    input  logic [W-1:0]      I_h_bporch,
    input  logic [W-1:0]      I_h_res,
    input  logic [W-1:0]      I_v_total,
    input  logic [W-1:0]      I_v_sync,
    input  logic [W-1:0]      I_v_bporch,
    input  logic [W-1:0]      I_v_res,
    input  logic              I_hs_pol,
    input  logic              I_vs_pol,
    output logic              O_cfg_err,
    output logic              O_running,
    output logic              O_req,
    output logic [W-1:0]      O_req_x,
    output logic [W-1:0]      O_req_y,
    output logic              O_de,
    output logic              O_hs,
    output logic              O_vs,
    output logic              O_sof,
    output logic              O_eol,
    output logic [FCNT_W-1:0] O_frame_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Delay line depth: raw timing reaches the transmitter PIPE_DLY cycles after the request.
    localparam int DL = PIPE_DLY + 1;

    localparam logic [W-1:0]      ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W+1:0]      ONE_X = {{(W+1){1'b0}}, 1'b1};
    localparam logic [FCNT_W-1:0] ONE_F = {{(FCNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [W-1:0] h_total;
        logic [W-1:0] h_sync;
        logic [W-1:0] h_bp;
        logic [W-1:0] h_res;
        logic [W-1:0] v_total;
        logic [W-1:0] v_sync;
        logic [W-1:0] v_bp;
        logic [W-1:0] v_res;
        logic         hs_pol;
        logic         vs_pol;
    } cfg_t;

    // Timing fields cleared, both polarities active-high.
    localparam cfg_t CFG_RST = cfg_t'({{(8*W){1'b0}}, 2'b11});

    logic [0:0]          state_q, state_d;
    logic                loaded_q, loaded_d;
    logic                pending_q, pending_d;
    logic                cfg_err_q, cfg_err_d;
    cfg_t                act_q, act_d;
    cfg_t                shd_q, shd_d;
    logic [W-1:0]        h_q, h_d;
    logic [W-1:0]        v_q, v_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                req_q, req_d;
    logic [W-1:0]        req_x_q, req_x_d;
    logic [W-1:0]        req_y_q, req_y_d;
    logic [DL-1:0][4:0]  dly_q, dly_d;

    cfg_t                cfg_in;
    logic                accept;
    logic                cfg_legal;
    logic [W+1:0]        h_sum, v_sum;
    logic                running;
    logic                h_wrap, v_wrap, frame_wrap;
    logic [W+1:0]        h_ext, v_ext;
    logic [W+1:0]        h_de_start, h_de_end, v_de_start, v_de_end;
    logic                raw_de, raw_hs, raw_vs, raw_sof, raw_eol;
    logic                hs_out, vs_out;
    logic [W-1:0]        col, row;

    // Offered config and its legality; sums are widened so large fields cannot wrap.
    always_comb begin
        cfg_in.h_total = I_h_total;
        cfg_in.h_sync  = I_h_sync;
        cfg_in.h_bp    = I_h_bporch;
        cfg_in.h_res   = I_h_res;
        cfg_in.v_total = I_v_total;
        cfg_in.v_sync  = I_v_sync;
        cfg_in.v_bp    = I_v_bporch;
        cfg_in.v_res   = I_v_res;
        cfg_in.hs_pol  = I_hs_pol;
        cfg_in.vs_pol  = I_vs_pol;
        h_sum = {2'b00, I_h_sync} + {2'b00, I_h_bporch} + {2'b00, I_h_res};
        v_sum = {2'b00, I_v_sync} + {2'b00, I_v_bporch} + {2'b00, I_v_res};
        cfg_legal = (I_h_sync != '0) && (I_h_res != '0) && (h_sum <= {2'b00, I_h_total}) &&
                    (I_v_sync != '0) && (I_v_res != '0) && (v_sum <= {2'b00, I_v_total});
        accept = I_cfg_valid && !pending_q;
    end

    // Raw timing decode from the H/V counters of the active config.
    always_comb begin
        running    = (state_q == ST_RUN);
        h_ext      = {2'b00, h_q};
        v_ext      = {2'b00, v_q};
        h_de_start = {2'b00, act_q.h_sync} + {2'b00, act_q.h_bp};
        h_de_end   = h_de_start + {2'b00, act_q.h_res};
        v_de_start = {2'b00, act_q.v_sync} + {2'b00, act_q.v_bp};
        v_de_end   = v_de_start + {2'b00, act_q.v_res};
        h_wrap     = (h_q == act_q.h_total - ONE_W);
        v_wrap     = (v_q == act_q.v_total - ONE_W);
        frame_wrap = running && h_wrap && v_wrap;
        raw_de     = running && (h_ext >= h_de_start) && (h_ext < h_de_end) &&
                     (v_ext >= v_de_start) && (v_ext < v_de_end);
        raw_hs     = running && (h_q < act_q.h_sync);
        raw_vs     = running && (v_q < act_q.v_sync);
        raw_sof    = running && (h_q == '0) && (v_q == '0);
        raw_eol    = raw_de && (h_ext + ONE_X == h_de_end);
        // Polarity is applied on entry to the delay line so trailing pixels keep the
        // polarity of the frame they belong to across a reconfiguration.
        hs_out     = act_q.hs_pol ? raw_hs : !raw_hs;
        vs_out     = act_q.vs_pol ? raw_vs : !raw_vs;
        col        = h_q - h_de_start[W-1:0];
        row        = v_q - v_de_start[W-1:0];
    end

    // Control: config load/shadow, run state, counters, request and delay line.
    always_comb begin
        state_d   = state_q;
        loaded_d  = loaded_q;
        pending_d = pending_q;
        act_d     = act_q;
        shd_d     = shd_q;
        h_d       = h_q;
        v_d       = v_q;
        fcnt_d    = fcnt_q;
        cfg_err_d = accept && !cfg_legal;
        req_d     = raw_de;
        req_x_d   = raw_de ? col : '0;
        req_y_d   = raw_de ? row : '0;
        dly_d[0]  = {raw_de, hs_out, vs_out, raw_sof, raw_eol};
        for (int i = 1; i < DL; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        if (state_q == ST_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (accept && cfg_legal) begin
                act_d    = cfg_in;
                loaded_d = 1'b1;
            end
            if (I_en && loaded_q) begin
                state_d = ST_RUN;
            end
        end else begin
            // A config accepted on the wrap cycle itself waits for the next wrap.
            if (accept && cfg_legal) begin
                shd_d     = cfg_in;
                pending_d = 1'b1;
            end
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + ONE_W;
            end else begin
                h_d = h_q + ONE_W;
            end
            if (frame_wrap) begin
                fcnt_d = fcnt_q + ONE_F;
                if (pending_q) begin
                    act_d     = shd_q;
                    pending_d = 1'b0;
                end
                if (!I_en) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // State registers; reset drops loaded and pending config at any point in the frame.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q   <= ST_IDLE;
            loaded_q  <= 1'b0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
            act_q     <= CFG_RST;
            shd_q     <= CFG_RST;
            h_q       <= '0;
            v_q       <= '0;
            fcnt_q    <= '0;
            req_q     <= 1'b0;
            req_x_q   <= '0;
            req_y_q   <= '0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            loaded_q  <= loaded_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fcnt_q    <= fcnt_d;
            req_q     <= req_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
            dly_q     <= dly_d;
        end
    end

    assign O_cfg_ready = !pending_q;
    assign O_cfg_err   = cfg_err_q;
    assign O_running   = (state_q == ST_RUN);
    assign O_req       = req_q;
    assign O_req_x     = req_x_q;
    assign O_req_y     = req_y_q;
    assign O_de        = dly_q[DL-1][4];
    assign O_hs        = dly_q[DL-1][3];
    assign O_vs        = dly_q[DL-1][2];
    assign O_sof       = dly_q[DL-1][1];
    assign O_eol       = dly_q[DL-1][0];
    assign O_frame_cnt = fcnt_q;

endmodule
